// File: rtl/datatape_pkg.sv
// rtl/datatape_pkg.sv - shared types and constants for the video output stream path
//
// Purpose: state encoding for the vout stream controller, default header magic,
//          default FIFO depth, and the saturating-increment helper.
// Ports:   none (package).

package datatape_pkg;

  localparam int          FIFO_DEPTH_DEF = 512;
  localparam logic [15:0] MAGIC_DEF      = 16'hDA7A;

  // Words kept free below FIFO_DEPTH to cover the dual-clock wrusedw lag.
  localparam int          FIFO_MARGIN    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR0   = 3'd1,
    HDR1   = 3'd2,
    SEQ    = 3'd3,
    PAY_HI = 3'd4,
    PAY_LO = 3'd5,
    DROP   = 3'd6
  } state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/sat_counter16.sv
// rtl/sat_counter16.sv - 16-bit saturating event counter
//
// Purpose: counts single-cycle inc pulses, sticking at 16'hFFFF.
// Ports:
//   clk   in   clock
//   rst   in   asynchronous active-low reset, clears count
//   inc   in   increment request for this cycle
//   count out  current count

module sat_counter16
  import datatape_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 16'd0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/vout_stream_ctrl.sv
// rtl/vout_stream_ctrl.sv - framed byte stream to nibble FIFO writer
//
// Purpose: parses frames of [magic hi][magic lo][seq][payload...] from a
//          valid/ready byte stream, splits payload bytes into two nibble writes
//          (high first) toward a video output FIFO, and keeps frame statistics.
// Ports:
//   clk                    in   125 MHz clock
//   rst                    in   asynchronous active-low reset
//   enable                 in   low: payload is consumed but not written
//   rx_data/valid/ready    byte stream handshake
//   rx_last/rx_user        end of frame / frame error (with rx_last)
//   vout_fifow_data        out  registered nibble to FIFO
//   vout_fifow_request     out  registered FIFO write strobe
//   vout_fifow_used_words  in   FIFO write-side fill level
//   frames_ok/frames_bad   out  saturating frame counters
//   seq_gaps               out  saturating sequence discontinuity counter
//   busy                   out  high when not in IDLE

module vout_stream_ctrl
  import datatape_pkg::*;
#(
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int          HIGH_WATER = 496,
  parameter logic [15:0] MAGIC      = MAGIC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        rx_last,
  input  logic        rx_user,
  output logic [3:0]  vout_fifow_data,
  output logic        vout_fifow_request,
  input  logic [8:0]  vout_fifow_used_words,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_bad,
  output logic [15:0] seq_gaps,
  output logic        busy
);

  // A threshold set too close to full is pulled down so the lagging fill
  // level can never let the FIFO overflow.
  localparam int HW_EFF = (HIGH_WATER > FIFO_DEPTH - FIFO_MARGIN) ?
                          (FIFO_DEPTH - FIFO_MARGIN) : HIGH_WATER;
  localparam logic [9:0] HW_W = 10'(HW_EFF);

  state_t      state;
  state_t      state_nxt;

  logic        ready_en;     // holds rx_ready low until the first edge after reset
  logic        fire;
  logic        below_hw;
  logic [7:0]  byte_q;
  logic        last_q;
  logic        wr_en_q;      // enable sampled with the byte so both nibbles agree
  logic [7:0]  seq_exp;

  logic        inc_ok;
  logic        inc_bad;
  logic        inc_gap;
  logic        seq_load;

  assign fire     = rx_valid & rx_ready;
  assign below_hw = ({1'b0, vout_fifow_used_words} < HW_W);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HDR0: begin
        if (fire) begin
          if (rx_last)                      state_nxt = IDLE;
          else if (rx_data == MAGIC[15:8])  state_nxt = HDR1;
          else                              state_nxt = DROP;
        end
      end
      HDR1: begin
        if (fire) begin
          if (rx_last)                      state_nxt = IDLE;
          else if (rx_data == MAGIC[7:0])   state_nxt = SEQ;
          else                              state_nxt = DROP;
        end
      end
      SEQ: begin
        if (fire) state_nxt = rx_last ? IDLE : PAY_HI;
      end
      PAY_HI: begin
        if (fire) state_nxt = PAY_LO;
      end
      PAY_LO: begin
        state_nxt = last_q ? IDLE : PAY_HI;
      end
      DROP: begin
        if (fire && rx_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    rx_ready = 1'b0;
    busy     = (state != IDLE);
    inc_ok   = 1'b0;
    inc_bad  = 1'b0;
    inc_gap  = 1'b0;
    seq_load = 1'b0;
    case (state)
      IDLE, HDR0, HDR1, SEQ, DROP: rx_ready = ready_en;
      PAY_HI:                      rx_ready = ready_en & below_hw;
      default:                     rx_ready = 1'b0;
    endcase
    // Only a frame ending on a payload byte without rx_user is good; endings
    // in header/seq states are runts, endings in DROP are bad magic.
    if (fire && rx_last) begin
      if (state == PAY_HI && !rx_user) inc_ok  = 1'b1;
      else                             inc_bad = 1'b1;
    end
    if (fire && state == SEQ && !rx_last) begin
      seq_load = 1'b1;
      inc_gap  = (rx_data != seq_exp);
    end
  end

  // Payload latch, registered FIFO outputs and sequence tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en           <= 1'b0;
      byte_q             <= 8'd0;
      last_q             <= 1'b0;
      wr_en_q            <= 1'b0;
      vout_fifow_data    <= 4'd0;
      vout_fifow_request <= 1'b0;
      seq_exp            <= 8'd0;
    end else begin
      ready_en           <= 1'b1;
      vout_fifow_request <= 1'b0;
      if (state == PAY_HI && fire) begin
        byte_q             <= rx_data;
        last_q             <= rx_last;
        wr_en_q            <= enable;
        vout_fifow_data    <= rx_data[7:4];
        vout_fifow_request <= enable;
      end else if (state == PAY_LO) begin
        vout_fifow_data    <= byte_q[3:0];
        vout_fifow_request <= wr_en_q;
      end
      if (seq_load) begin
        seq_exp <= rx_data + 8'd1;
      end
    end
  end

  sat_counter16 u_cnt_ok (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_ok),
    .count (frames_ok)
  );

  sat_counter16 u_cnt_bad (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_bad),
    .count (frames_bad)
  );

  sat_counter16 u_cnt_gap (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_gap),
    .count (seq_gaps)
  );

endmodule

// File: tb/tb_vout_stream_ctrl.sv
// tb/tb_vout_stream_ctrl.sv - scoreboard bench for vout_stream_ctrl

module tb_vout_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        rx_last = 1'b0;
  logic        rx_user = 1'b0;
  logic [3:0]  vout_fifow_data;
  logic        vout_fifow_request;
  logic [8:0]  vout_fifow_used_words = 9'd0;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;
  logic [15:0] seq_gaps;
  logic        busy;

  vout_stream_ctrl dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .rx_data               (rx_data),
    .rx_valid              (rx_valid),
    .rx_ready              (rx_ready),
    .rx_last               (rx_last),
    .rx_user               (rx_user),
    .vout_fifow_data       (vout_fifow_data),
    .vout_fifow_request    (vout_fifow_request),
    .vout_fifow_used_words (vout_fifow_used_words),
    .frames_ok             (frames_ok),
    .frames_bad            (frames_bad),
    .seq_gaps              (seq_gaps),
    .busy                  (busy)
  );

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] nib;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every write must match the next expected nibble and cycle.
  always @(negedge clk) begin
    if (rst && vout_fifow_request) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got nibble 0x%0h at cycle %0d, expected no write",
                 vout_fifow_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.nib == vout_fifow_data && e.at == cyc) n_pass++;
        else $display("FAIL fifo_write: got 0x%0h at cycle %0d, expected 0x%0h at cycle %0d",
                      vout_fifow_data, cyc, e.nib, e.at);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, input int n);
    exp_t e;
    e.nib = b[7:4]; e.at = n + 1; exp_q.push_back(e);
    e.nib = b[3:0]; e.at = n + 2; exp_q.push_back(e);
  endtask

  // Drives one byte and waits for acceptance; pay marks a payload byte.
  task automatic send_byte(input logic [7:0] b, input bit last, input bit user, input bit pay);
    bit acc;
    acc = 1'b0;
    rx_data = b; rx_last = last; rx_user = user; rx_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (rx_ready) begin
        acc = 1'b1;
        if (pay && enable) push_byte(b, cyc);
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag, input int ok, input int bad, input int gaps);
    check({tag, "_ok"},   frames_ok,  ok);
    check({tag, "_bad"},  frames_bad, bad);
    check({tag, "_gaps"}, seq_gaps,   gaps);
    check({tag, "_busy"}, busy,       0);
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_ready", rx_ready, 0);
    check("rst_req",   vout_fifow_request, 0);
    check("rst_data",  vout_fifow_data, 0);
    check("rst_busy",  busy, 0);
    check_counts("rst", 0, 0, 0);
    rst = 1'b1;
    idle(1);
    check("ready_after_rst", rx_ready, 1);

    // DA 7A 00 12 34: nibbles 1,2,3,4 on consecutive cycles, seq matches 0
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'h12, 0, 0, 1);
    send_byte(8'h34, 1, 0, 1);
    idle(3);
    check_counts("f1", 1, 0, 0);

    // In-sequence frame then a jump from 02 to 05
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h01, 0, 0, 0);
    send_byte(8'hAB, 1, 0, 1);
    idle(3);
    check_counts("f2", 2, 0, 0);
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h05, 0, 0, 0);
    send_byte(8'hCD, 1, 0, 1);
    idle(3);
    check_counts("f3", 3, 0, 1);

    // Bad magic: dropped, no writes
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h00, 0, 0, 0);
    send_byte(8'hFF, 0, 0, 0);
    send_byte(8'hFF, 1, 0, 0);
    idle(3);
    check_counts("f4", 3, 1, 1);

    // High-water backpressure in PAY_HI
    vout_fifow_used_words = 9'd496;
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h06, 0, 0, 0);
    rx_data = 8'h5A; rx_last = 1'b1; rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hw_stall_ready", rx_ready, 0);
      @(posedge clk); #1;
    end
    vout_fifow_used_words = 9'd495;
    send_byte(8'h5A, 1, 0, 1);
    vout_fifow_used_words = 9'd0;
    idle(3);
    check_counts("f5", 4, 1, 1);

    // rx_user on last: nibbles still written, frame counted bad
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h07, 0, 0, 0);
    send_byte(8'h9C, 1, 1, 1);
    idle(3);
    check_counts("f6", 4, 2, 1);

    // enable low: payload consumed without writes, frame still good
    enable = 1'b0;
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h08, 0, 0, 0);
    send_byte(8'h3E, 1, 0, 1);
    idle(3);
    enable = 1'b1;
    check_counts("f7", 5, 2, 1);

    // rx_valid gap mid-frame: stall with no writes
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h09, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_busy", busy, 1);
      @(posedge clk); #1;
    end
    send_byte(8'h77, 1, 0, 1);
    idle(3);
    check_counts("f8", 6, 2, 1);

    // Runt frame ending in HDR1
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 1, 0, 0);
    idle(2);
    check_counts("runt", 6, 3, 1);

    // Reset during PAY_LO: high nibble only, then clean restart
    send_byte(8'hDA, 0, 0, 0);
    send_byte(8'h7A, 0, 0, 0);
    send_byte(8'h0A, 0, 0, 0);
    rx_data = 8'h4B; rx_valid = 1'b1;
    begin
      bit acc;
      acc = 1'b0;
      for (int n = 0; n < 50 && !acc; n++) begin
        @(negedge clk);
        if (rx_ready) begin
          acc = 1'b1;
          begin
            exp_t e;
            e.nib = 4'h4; e.at = cyc + 1;
            exp_q.push_back(e);
          end
        end
        @(posedge clk); #1;
      end
      if (!acc) check("accept_timeout", 0, 1);
    end
    rx_valid = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    idle(2);
    check("mid_rst_req",   vout_fifow_request, 0);
    check("mid_rst_ready", rx_ready, 0);
    check_counts("mid_rst", 0, 0, 0);
    rst = 1'b1;
    idle(1);
    check("mid_rst_ready_after", rx_ready, 1);
    check("mid_rst_busy_after",  busy, 0);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
